// File: rtl/pe_out_chan.sv
// Output channel behind the PE functional unit: in-order result buffer with per-destination fan-out.
// Optional same-cycle bypass of an empty buffer is enabled by defining PE_OUT_BYPASS_EN.
module pe_out_chan #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int NUM_DST    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  cfg_we,
  input  logic [NUM_DST-1:0]    cfg_dst_en,
  output logic                  fu_ready,
  input  logic                  fu_alloc,
  input  logic                  fu_valid,
  input  logic [DATA_WIDTH-1:0] fu_out,
  output logic [NUM_DST-1:0]    out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [NUM_DST-1:0]    out_ack,
  output logic                  proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  ptr_t                  head, tail, wr;
  cnt_t                  n_res, n_full;
  logic [NUM_DST-1:0]    taken, dst_en;

  logic                  alloc_acc, wr_acc, head_vld, byp;
  logic                  retire_head, byp_drop, idle;
  logic [NUM_DST-1:0]    ack_acc, done;
  logic [CW:0]           occ;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign occ      = {1'b0, n_res} + {1'b0, n_full};
  assign fu_ready = (occ != (CW+1)'(DEPTH));
  assign idle     = (n_res == '0) && (n_full == '0);

  always_comb begin
    alloc_acc = fu_alloc && fu_ready;
    wr_acc    = fu_valid && ((n_res != '0) || alloc_acc);
    head_vld  = (n_full != '0);
    byp       = 1'b0;
`ifdef PE_OUT_BYPASS_EN
    byp       = wr_acc && !head_vld;
`endif
    out_data  = byp ? fu_out : mem[head];
    if (byp)
      out_valid = dst_en;
    else if (head_vld)
      out_valid = dst_en & ~taken;
    else
      out_valid = '0;
    ack_acc     = out_ack & out_valid;
    done        = taken | ack_acc | ~dst_en;
    retire_head = head_vld && (&done);
    // A fully acknowledged bypass result never occupies a slot.
    byp_drop    = byp && (&done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      wr        <= '0;
      n_res     <= '0;
      n_full    <= '0;
      taken     <= '0;
      dst_en    <= '0;
      proto_err <= 1'b0;
    end else if (clear) begin
      head      <= '0;
      tail      <= '0;
      wr        <= '0;
      n_res     <= '0;
      n_full    <= '0;
      taken     <= '0;
      proto_err <= 1'b0;
    end else begin
      if (alloc_acc) tail <= ptr_inc(tail);
      if (wr_acc)    wr   <= ptr_inc(wr);
      if (retire_head || byp_drop) head <= ptr_inc(head);

      n_res <= n_res + cnt_t'(alloc_acc) - cnt_t'(wr_acc);

      case ({wr_acc && !byp_drop, retire_head})
        2'b10:   n_full <= n_full + cnt_t'(1);
        2'b01:   n_full <= n_full - cnt_t'(1);
        default: n_full <= n_full;
      endcase

      taken <= (retire_head || byp_drop) ? '0 : (taken | ack_acc);

      if (cfg_we && idle) dst_en <= cfg_dst_en;

      if ((fu_alloc && !fu_ready) || (fu_valid && !wr_acc) || (cfg_we && !idle))
        proto_err <= 1'b1;
    end
  end

  // ---- result storage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc && !clear) begin
      mem[wr] <= fu_out;
    end
  end

endmodule

// File: tb/tb_pe_out_chan.sv
// Self-checking bench for pe_out_chan: directed scenarios plus randomized traffic against a queue model.
module tb_pe_out_chan;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int ND    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          cfg_we = 1'b0;
  logic [ND-1:0] cfg_dst_en = '0;
  logic          fu_ready;
  logic          fu_alloc = 1'b0;
  logic          fu_valid = 1'b0;
  logic [DW-1:0] fu_out = '0;
  logic [ND-1:0] out_valid;
  logic [DW-1:0] out_data;
  logic [ND-1:0] out_ack = '0;
  logic          proto_err;

  always #5 clk = ~clk;

  pe_out_chan #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_DST(ND)) dut (
    .clk(clk), .rst(rst), .clear(clear), .cfg_we(cfg_we), .cfg_dst_en(cfg_dst_en),
    .fu_ready(fu_ready), .fu_alloc(fu_alloc), .fu_valid(fu_valid), .fu_out(fu_out),
    .out_valid(out_valid), .out_data(out_data), .out_ack(out_ack), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: reservation count plus a queue of written, unretired results.
  int            m_res = 0;
  logic [DW-1:0] m_q[$];
  logic [ND-1:0] m_taken = '0;
  logic [ND-1:0] m_en = '0;
  bit            m_perr = 0;

  function automatic void model_outs(output bit rdy, output logic [ND-1:0] ov,
                                     output logic [DW-1:0] od, output bit known,
                                     output bit aok, output bit wok, output bit byp);
    rdy = (m_res + m_q.size()) < DEPTH;
    aok = fu_alloc && rdy;
    wok = fu_valid && ((m_res > 0) || aok);
    byp = 0;
`ifdef PE_OUT_BYPASS_EN
    byp = wok && (m_q.size() == 0);
`endif
    if (byp) begin
      ov = m_en; od = fu_out; known = 1;
    end else if (m_q.size() > 0) begin
      ov = m_en & ~m_taken; od = m_q[0]; known = 1;
    end else begin
      ov = '0; od = '0; known = 0;
    end
  endfunction

  task automatic model_step();
    bit rdy, aok, wok, byp, known, consumed, was_idle;
    logic [ND-1:0] ov, acc, done;
    logic [DW-1:0] od;
    int sz;
    if (rst) begin
      m_res = 0; m_q.delete(); m_taken = '0; m_en = '0; m_perr = 0;
      return;
    end
    if (clear) begin
      m_res = 0; m_q.delete(); m_taken = '0; m_perr = 0;
      return;
    end
    model_outs(rdy, ov, od, known, aok, wok, byp);
    sz = m_q.size();
    was_idle = (m_res == 0) && (sz == 0);
    if (fu_alloc && !rdy) m_perr = 1;
    if (fu_valid && !wok) m_perr = 1;
    acc = out_ack & ov;
    done = m_taken | acc | ~m_en;
    consumed = 0;
    if (sz > 0 || byp) begin
      if (&done) begin
        m_taken = '0;
        if (sz > 0) void'(m_q.pop_front());
        else consumed = 1;
      end else begin
        m_taken = m_taken | acc;
      end
    end
    if (cfg_we) begin
      if (was_idle) m_en = cfg_dst_en;
      else m_perr = 1;
    end
    m_res = m_res + int'(aok) - int'(wok);
    if (wok && !consumed) m_q.push_back(fu_out);
  endtask

  task automatic compare_all();
    bit rdy, aok, wok, byp, known;
    logic [ND-1:0] ov;
    logic [DW-1:0] od;
    model_outs(rdy, ov, od, known, aok, wok, byp);
    check_val("fu_ready", fu_ready, rdy);
    check_val("out_valid", out_valid, ov);
    check_val("proto_err", proto_err, m_perr);
    if (known) check_val("out_data", out_data, od);
  endtask

  task automatic idle_inputs();
    rst = 0; clear = 0; cfg_we = 0; cfg_dst_en = '0;
    fu_alloc = 0; fu_valid = 0; fu_out = '0; out_ack = '0;
  endtask

  // One clock: apply inputs, compare mid-cycle, advance model at the edge, return inputs to idle.
  task automatic drive(input bit a, input bit v, input logic [DW-1:0] d, input logic [ND-1:0] ack,
                       input bit cw, input logic [ND-1:0] cfg, input bit clr, input bit r);
    fu_alloc = a; fu_valid = v; fu_out = d; out_ack = ack;
    cfg_we = cw; cfg_dst_en = cfg; clear = clr; rst = r;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
    idle_inputs();
  endtask

  initial begin
    @(posedge clk);
    #1;
    drive(0, 0, 0, 4'h0, 0, 4'h0, 0, 1);
    check_val("rst_ready", fu_ready, 1'b1);
    check_val("rst_valid", out_valid, 4'h0);
    check_val("rst_data", out_data, 32'h0);
    check_val("rst_perr", proto_err, 1'b0);

    drive(0, 0, 0, 4'h0, 1, 4'b0101, 0, 0);
    drive(1, 1, 32'hA5, 4'h0, 0, 4'h0, 0, 0);
    check_val("a5_valid", out_valid, 4'b0101);
    check_val("a5_data", out_data, 32'hA5);
    drive(0, 0, 0, 4'b0001, 0, 4'h0, 0, 0);
    check_val("ack0_valid", out_valid, 4'b0100);
    drive(0, 0, 0, 4'h0, 0, 4'h0, 0, 0);
    check_val("hold_valid", out_valid, 4'b0100);
    drive(0, 0, 0, 4'b0100, 0, 4'h0, 0, 0);
    check_val("retire_valid", out_valid, 4'h0);
    check_val("retire_ready", fu_ready, 1'b1);

    drive(1, 0, 0, 4'h0, 0, 4'h0, 0, 0);
    drive(1, 0, 0, 4'h0, 0, 4'h0, 0, 0);
    check_val("full_ready", fu_ready, 1'b0);
    drive(1, 0, 0, 4'h0, 0, 4'h0, 0, 0);
    check_val("extra_alloc_perr", proto_err, 1'b1);
    check_val("extra_alloc_ready", fu_ready, 1'b0);
    drive(0, 1, 32'h1, 4'h0, 0, 4'h0, 0, 0);
    check_val("order_first", out_data, 32'h1);
    drive(0, 1, 32'h2, 4'h0, 0, 4'h0, 0, 0);
    check_val("full2_ready", fu_ready, 1'b0);
    drive(1, 0, 0, 4'hF, 0, 4'h0, 0, 0);
    check_val("retire_full_ready", fu_ready, 1'b1);
    check_val("order_second", out_data, 32'h2);
    check_val("order_second_valid", out_valid, 4'b0101);
    drive(0, 0, 0, 4'b0101, 0, 4'h0, 0, 0);
    check_val("drained_valid", out_valid, 4'h0);

    drive(0, 0, 0, 4'h0, 0, 4'h0, 1, 0);
    check_val("clear_perr", proto_err, 1'b0);
    drive(1, 1, 32'h3, 4'h0, 0, 4'h0, 0, 0);
    drive(1, 1, 32'h4, 4'h0, 0, 4'h0, 0, 0);
    drive(0, 0, 0, 4'h0, 1, 4'hF, 0, 0);
    check_val("busy_cfg_perr", proto_err, 1'b1);
    drive(0, 0, 0, 4'h0, 0, 4'h0, 1, 0);
    check_val("clear_valid", out_valid, 4'h0);
    check_val("clear_ready", fu_ready, 1'b1);
    drive(1, 1, 32'h5, 4'h0, 0, 4'h0, 0, 0);
    check_val("dst_en_kept", out_valid, 4'b0101);
    check_val("post_clear_data", out_data, 32'h5);
    drive(1, 1, 32'h6, 4'h0, 0, 4'h0, 0, 0);
    drive(0, 0, 0, 4'h0, 0, 4'h0, 0, 1);
    check_val("rst_mid_valid", out_valid, 4'h0);
    check_val("rst_mid_ready", fu_ready, 1'b1);
    check_val("rst_mid_data", out_data, 32'h0);
    drive(1, 1, 32'h7, 4'h0, 0, 4'h0, 0, 0);
    check_val("no_dst_valid", out_valid, 4'h0);
    drive(0, 0, 0, 4'h0, 0, 4'h0, 0, 0);
    check_val("no_dst_retired", fu_ready, 1'b1);

`ifdef PE_OUT_BYPASS_EN
    drive(0, 0, 0, 4'h0, 1, 4'b0101, 0, 0);
    fu_alloc = 1; fu_valid = 1; fu_out = 32'h7; out_ack = 4'b0101;
    #1;
    check_val("byp_valid", out_valid, 4'b0101);
    check_val("byp_data", out_data, 32'h7);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
    idle_inputs();
    check_val("byp_not_stored", out_valid, 4'h0);
    check_val("byp_ready", fu_ready, 1'b1);
`endif

    for (int i = 0; i < 3000; i++) begin
      bit a, v, cw, clr, r;
      a   = ($urandom_range(0, 99) < 50);
      v   = ($urandom_range(0, 99) < 50);
      cw  = ($urandom_range(0, 99) < 5);
      clr = ($urandom_range(0, 99) < 1);
      r   = ($urandom_range(0, 999) < 5);
      drive(a, v, $urandom, 4'($urandom), cw, 4'($urandom), clr, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_out_chan.md
Name: pe_out_chan

Overview:
- Output channel stage directly downstream of the PE functional unit. Receives FU results through an allocate-then-write protocol (fu_alloc, then fu_valid/fu_out).
- Buffers up to DEPTH results in order and fans each result out to up to NUM_DST consumers. Each consumer has its own valid/ack pair.
- An entry retires only when every enabled destination has acknowledged it. The freed slot is then returned to the FU through fu_ready.

Parameters:
- DATA_WIDTH, 32, result width.
- DEPTH, 2, buffer slots; must be 2..8.
- NUM_DST, 4, fan-out destinations; must be 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous flush; keeps configuration.
- cfg_we  in  1  configuration write strobe.
- cfg_dst_en  in  NUM_DST  destination enable mask.
- fu_ready  out  1  a free slot exists for allocation.
- fu_alloc  in  1  reserve one slot.
- fu_valid  in  1  write result into the oldest reserved slot.
- fu_out  in  DATA_WIDTH  result data.
- out_valid  out  NUM_DST  per-destination head valid.
- out_data  out  DATA_WIDTH  head entry data, shared by all destinations.
- out_ack  in  NUM_DST  per-destination accept.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- State registers:
  - Circular buffer with head, tail and wr pointers.
  - Counters n_res (reserved, unwritten) and n_full (written, unretired).
  - taken[NUM_DST] for the head entry.
  - dst_en[NUM_DST].
  - proto_err.
- Invariant: n_res + n_full <= DEPTH. free = DEPTH - n_res - n_full.
- fu_ready = (free != 0), decoded from registered counters only. A slot retired in cycle t raises fu_ready in t+1.
- Allocation:
  - Accepted when fu_alloc && fu_ready; n_res increments.
  - fu_alloc while !fu_ready is ignored and sets proto_err.
- Write:
  - Accepted when fu_valid && (n_res != 0 || accepted alloc in the same cycle).
  - Data goes to slot wr; wr advances; n_res decrements; n_full increments.
  - Simultaneous alloc+write: net n_res unchanged.
  - fu_valid with no reservation is ignored and sets proto_err.
- Head presentation:
  - out_data = buffer[head].
  - out_valid[i] = (n_full != 0) && dst_en[i] && !taken[i].
  - A write in cycle t is visible on out_valid at t+1; entries are presented strictly in order.
- Ack:
  - out_ack[i] counts only when out_valid[i]=1. An ack without valid is ignored (no error).
  - done = taken | (out_ack & out_valid) | ~dst_en.
  - If done is all-ones and n_full != 0: retire head, advance head, decrement n_full, clear taken.
  - Otherwise: taken |= out_ack & out_valid.
  - Different destinations may ack in different cycles. A destination that has acked sees valid drop until the next entry.
- dst_en == 0: each written entry retires one cycle after reaching head; no out_valid is raised.
- Write and retire in the same cycle are allowed: n_full is unchanged. With DEPTH slots full and retiring, fu_ready still rises only at t+1.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
- Configuration: cfg_we loads dst_en only when n_res == 0 && n_full == 0. Otherwise it is ignored and sets proto_err.
- clear:
  - Zeroes pointers, counters and taken; dst_en is retained; proto_err is cleared.
  - clear has priority over alloc, write, ack and cfg in the same cycle.
- Reset (rst, including mid-operation):
  - fu_ready=1, out_valid=0, out_data=0, proto_err=0.
  - dst_en=0, counters, pointers and taken all 0.
  - The buffer is zeroed.

Optional Feature:
- Macro: PE_OUT_BYPASS_EN.
- When defined, a write with n_full==0 is presented combinationally in the same cycle:
  - out_data = fu_out.
  - out_valid[i] = dst_en[i].
- Bypass acks:
  - If all enabled destinations ack in that cycle, the result is consumed without being stored: n_res decrements, n_full stays 0, wr and head both advance.
  - Partial acks are recorded in taken and the entry is stored normally.
- Without the macro, every result takes at least one cycle from fu_valid to out_valid.

Test Plan:
- Reset with dst_en=4'b0101, DEPTH=2 → fu_ready=1, out_valid=0. Then alloc+write 0xA5 in cycle t → out_valid=4'b0101 and out_data=0xA5 at t+1.
- Ack dst0 at t+1 and dst2 at t+3 → out_valid=4'b0100 at t+2; entry retires at t+3; out_valid=0 and fu_ready=1 at t+4.
- Allocate twice with no acks → fu_ready=0. Extra fu_alloc → proto_err=1 and n_res unchanged. Write 0x1, then 0x2 → delivered in order 0x1, 0x2.
- Full buffer; in one cycle all destinations ack the head while fu_alloc is asserted → alloc ignored that cycle; fu_ready=1 next cycle.
- Mid-stream clear, and separately rst, with 2 entries pending → all out_valid=0 next cycle; dst_en retained after clear, zero after rst. cfg_we while busy → ignored and proto_err=1.
- PE_OUT_BYPASS_EN, empty buffer, alloc+write 0x7 with all enabled destinations acking the same cycle → out_valid seen in cycle t; nothing stored; n_full stays 0.
